// File: rtl/cmac_req_sched.sv
// rtl/cmac_req_sched.sv - round-robin scheduler for a shared pipelined complex FP MAC
//
// Purpose: shares one fixed-latency complex MUL/ADD datapath among NUM_REQ
// requesters. At most one op issues per cycle; each op is tagged with its
// requester index, tracked through a per-op-type shift register, and its
// result is captured into that requester's response register.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   req_valid_i/ready_o     per-requester issue handshake (ready is a one-hot grant)
//   req_op_i                0 = ADD (c+d), 1 = MUL (a*b)
//   req_rnd_i, req_op*_i    per-requester rounding mode and operands (slice i)
//   cm_rnd_o, cm_op*_o      winner's rounding mode/operands to the datapath
//   cm_out_mul_i/add_i      datapath results
//   resp_valid_o/ready_i    per-requester result handshake
//   resp_data_o             per-requester result (slice i)
//   busy_o                  any op in flight or response held
module cmac_req_sched #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REQ    = 4,
    parameter int MUL_LAT    = 2,
    parameter int ADD_LAT    = 1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NUM_REQ-1:0]                req_valid_i,
    output logic [NUM_REQ-1:0]                req_ready_o,
    input  logic [NUM_REQ-1:0]                req_op_i,
    input  logic [3*NUM_REQ-1:0]              req_rnd_i,
    input  logic [2*DATA_WIDTH*NUM_REQ-1:0]   req_opa_i,
    input  logic [2*DATA_WIDTH*NUM_REQ-1:0]   req_opb_i,
    input  logic [2*DATA_WIDTH*NUM_REQ-1:0]   req_opc_i,
    input  logic [2*DATA_WIDTH*NUM_REQ-1:0]   req_opd_i,
    output logic [2:0]                        cm_rnd_o,
    output logic [2*DATA_WIDTH-1:0]           cm_opa_o,
    output logic [2*DATA_WIDTH-1:0]           cm_opb_o,
    output logic [2*DATA_WIDTH-1:0]           cm_opc_o,
    output logic [2*DATA_WIDTH-1:0]           cm_opd_o,
    input  logic [2*DATA_WIDTH-1:0]           cm_out_mul_i,
    input  logic [2*DATA_WIDTH-1:0]           cm_out_add_i,
    output logic [NUM_REQ-1:0]                resp_valid_o,
    input  logic [NUM_REQ-1:0]                resp_ready_i,
    output logic [2*DATA_WIDTH*NUM_REQ-1:0]   resp_data_o,
    output logic                              busy_o
);

    localparam int CW = 2 * DATA_WIDTH;
    localparam int TW = $clog2(NUM_REQ);

    logic [TW-1:0]         ptr_q;
    logic [NUM_REQ-1:0]    outstanding_q, outstanding_d;
    logic [NUM_REQ-1:0]    resp_valid_q, resp_valid_d;
    logic [CW*NUM_REQ-1:0] resp_data_q, resp_data_d;

    logic [MUL_LAT-1:0]    mul_vld_q;
    logic [TW-1:0]         mul_tag_q [MUL_LAT];
    logic [ADD_LAT-1:0]    add_vld_q;
    logic [TW-1:0]         add_tag_q [ADD_LAT];

    logic [NUM_REQ-1:0]    eligible;
    logic                  win_found;
    logic [TW-1:0]         win_idx;
    logic [TW-1:0]         cand;
    int                    idx;
    logic                  issue_mul_d, issue_add_d;
    logic                  mul_cap, add_cap;
    logic [TW-1:0]         mul_cap_tag, add_cap_tag;
    logic [NUM_REQ-1:0]    resp_hs;

    // Round-robin search starting one past the last winner. A requester
    // with a result still pending is not eligible, so at most one op per
    // requester is ever in flight and tags never collide.
    always_comb begin
        eligible  = req_valid_i & ~outstanding_q;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        idx       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx  = (int'(ptr_q) + k) % NUM_REQ;
            cand = TW'(idx);
            if (!win_found && eligible[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        cm_rnd_o    = '0;
        cm_opa_o    = '0;
        cm_opb_o    = '0;
        cm_opc_o    = '0;
        cm_opd_o    = '0;
        issue_mul_d = 1'b0;
        issue_add_d = 1'b0;
        if (win_found) begin
            req_ready_o[win_idx] = 1'b1;
            cm_rnd_o    = req_rnd_i[win_idx*3 +: 3];
            cm_opa_o    = req_opa_i[win_idx*CW +: CW];
            cm_opb_o    = req_opb_i[win_idx*CW +: CW];
            cm_opc_o    = req_opc_i[win_idx*CW +: CW];
            cm_opd_o    = req_opd_i[win_idx*CW +: CW];
            issue_mul_d = req_op_i[win_idx];
            issue_add_d = ~req_op_i[win_idx];
        end
    end

    // Last stage of each tracker lines up with the cycle the datapath
    // presents that op's result.
    assign mul_cap     = mul_vld_q[MUL_LAT-1];
    assign mul_cap_tag = mul_tag_q[MUL_LAT-1];
    assign add_cap     = add_vld_q[ADD_LAT-1];
    assign add_cap_tag = add_tag_q[ADD_LAT-1];
    assign resp_hs     = resp_valid_q & resp_ready_i;

    always_comb begin
        outstanding_d = outstanding_q & ~resp_hs;
        resp_valid_d  = resp_valid_q & ~resp_hs;
        resp_data_d   = resp_data_q;
        if (win_found) begin
            outstanding_d[win_idx] = 1'b1;
        end
        // MUL and ADD may both land in one cycle, always for different tags.
        if (mul_cap) begin
            resp_valid_d[mul_cap_tag]           = 1'b1;
            resp_data_d[mul_cap_tag*CW +: CW]   = cm_out_mul_i;
        end
        if (add_cap) begin
            resp_valid_d[add_cap_tag]           = 1'b1;
            resp_data_d[add_cap_tag*CW +: CW]   = cm_out_add_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q         <= TW'(NUM_REQ - 1);
            outstanding_q <= '0;
            resp_valid_q  <= '0;
            resp_data_q   <= '0;
            mul_vld_q     <= '0;
            add_vld_q     <= '0;
            for (int k = 0; k < MUL_LAT; k++) mul_tag_q[k] <= '0;
            for (int k = 0; k < ADD_LAT; k++) add_tag_q[k] <= '0;
        end else begin
            if (win_found) begin
                ptr_q <= win_idx;
            end
            outstanding_q <= outstanding_d;
            resp_valid_q  <= resp_valid_d;
            resp_data_q   <= resp_data_d;
            mul_vld_q[0]  <= issue_mul_d;
            mul_tag_q[0]  <= win_idx;
            for (int k = 1; k < MUL_LAT; k++) begin
                mul_vld_q[k] <= mul_vld_q[k-1];
                mul_tag_q[k] <= mul_tag_q[k-1];
            end
            add_vld_q[0]  <= issue_add_d;
            add_tag_q[0]  <= win_idx;
            for (int k = 1; k < ADD_LAT; k++) begin
                add_vld_q[k] <= add_vld_q[k-1];
                add_tag_q[k] <= add_tag_q[k-1];
            end
        end
    end

    assign resp_valid_o = resp_valid_q;
    assign resp_data_o  = resp_data_q;
    assign busy_o       = |outstanding_q;

    a_cap_same_tag: assert property (@(posedge clk_i) disable iff (rst_i)
        !(mul_cap && add_cap && (mul_cap_tag == add_cap_tag)));
    a_mul_cap_on_hs: assert property (@(posedge clk_i) disable iff (rst_i)
        !(mul_cap && resp_hs[mul_cap_tag]));
    a_add_cap_on_hs: assert property (@(posedge clk_i) disable iff (rst_i)
        !(add_cap && resp_hs[add_cap_tag]));

endmodule

// File: tb/tb_cmac_req_sched.sv
// tb/tb_cmac_req_sched.sv - scoreboard bench for cmac_req_sched
module tb_cmac_req_sched;

    localparam int NR = 4;
    localparam int CW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NR-1:0]    req_valid, req_ready, req_op;
    logic [3*NR-1:0]  req_rnd;
    logic [CW*NR-1:0] req_opa, req_opb, req_opc, req_opd;
    logic [2:0]       cm_rnd;
    logic [CW-1:0]    cm_opa, cm_opb, cm_opc, cm_opd, cm_out_mul, cm_out_add;
    logic [NR-1:0]    resp_valid, resp_ready;
    logic [CW*NR-1:0] resp_data;
    logic             busy;

    cmac_req_sched #(.DATA_WIDTH(16), .NUM_REQ(NR), .MUL_LAT(2), .ADD_LAT(1)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
        .req_rnd_i(req_rnd), .req_opa_i(req_opa), .req_opb_i(req_opb),
        .req_opc_i(req_opc), .req_opd_i(req_opd),
        .cm_rnd_o(cm_rnd), .cm_opa_o(cm_opa), .cm_opb_o(cm_opb),
        .cm_opc_o(cm_opc), .cm_opd_o(cm_opd),
        .cm_out_mul_i(cm_out_mul), .cm_out_add_i(cm_out_add),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_data_o(resp_data), .busy_o(busy)
    );

    // Datapath stand-in: known FP vectors give their true results, anything
    // else gives a+b (MUL) or c^d (ADD) so expected values stay hand-checkable.
    function automatic logic [31:0] mul_fn(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3C00_4000 && b == 32'h4200_3C00) return 32'h3C00_4700;
        return a + b;
    endfunction
    function automatic logic [31:0] add_fn(input logic [31:0] c, input logic [31:0] d);
        if (c == 32'h3C00_3C00 && d == 32'h4000_4000) return 32'h4200_4200;
        return c ^ d;
    endfunction

    logic [31:0] mul_p1 = '0, mul_p2 = '0, add_p1 = '0;
    always @(posedge clk) begin
        mul_p1 <= mul_fn(cm_opa, cm_opb);
        mul_p2 <= mul_p1;
        add_p1 <= add_fn(cm_opc, cm_opd);
    end
    assign cm_out_mul = mul_p2;
    assign cm_out_add = add_p1;

    logic [31:0] op_a [NR], op_b [NR], op_c [NR], op_d [NR], exp_res [NR];
    logic [2:0]  op_rnd [NR];
    logic        op_mul [NR];

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            req_opa[i*CW +: CW] = op_a[i];
            req_opb[i*CW +: CW] = op_b[i];
            req_opc[i*CW +: CW] = op_c[i];
            req_opd[i*CW +: CW] = op_d[i];
            req_rnd[i*3 +: 3]   = op_rnd[i];
            req_op[i]           = op_mul[i];
        end
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int          idx;
        logic [31:0] data;
        int          cyc;
    } sb_t;
    sb_t sb_q[$];
    int  acc_idx[$];
    int  acc_cyc[$];
    bit  auto_drop = 1'b1;
    bit  drop_pend [NR];
    bit  seen [NR];

    // Issue monitor: records grants and pushes the expected response.
    always @(negedge clk) begin
        if (!rst) begin
            if (req_ready != '0) begin
                check("grant_onehot", 64'($onehot(req_ready)), 64'd1);
                check("grant_subset_valid", 64'(req_ready & ~req_valid), 64'd0);
            end else begin
                check("idle_cm_zero", {cm_opa, cm_opb[31:0] ^ cm_opc ^ cm_opd}, 64'd0);
                check("idle_cm_rnd", 64'(cm_rnd), 64'd0);
            end
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    acc_idx.push_back(i);
                    acc_cyc.push_back(cyc);
                    check("cm_opa_mux", 64'(cm_opa), 64'(op_a[i]));
                    check("cm_opd_mux", 64'(cm_opd), 64'(op_d[i]));
                    check("cm_rnd_mux", 64'(cm_rnd), 64'(op_rnd[i]));
                    sb_q.push_back('{idx: i, data: exp_res[i], cyc: cyc + (op_mul[i] ? 3 : 2)});
                    if (auto_drop) drop_pend[i] = 1'b1;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NR; i++) begin
            if (drop_pend[i]) begin
                req_valid[i] = 1'b0;
                drop_pend[i] = 1'b0;
            end
        end
    end

    // Response monitor: the first cycle a response is presented it must match
    // the oldest expectation for that requester, in data and arrival cycle.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NR; i++) begin
                if (resp_valid[i] && !seen[i]) begin
                    int f;
                    f = -1;
                    for (int j = 0; j < sb_q.size(); j++)
                        if (f < 0 && sb_q[j].idx == i) f = j;
                    if (f < 0) begin
                        check($sformatf("unexpected_resp_r%0d", i), 64'(resp_valid[i]), 64'd0);
                    end else begin
                        check($sformatf("resp_data_r%0d", i), 64'(resp_data[i*CW +: CW]), 64'(sb_q[f].data));
                        check($sformatf("resp_cycle_r%0d", i), 64'(cyc), 64'(sb_q[f].cyc));
                        sb_q.delete(f);
                    end
                    seen[i] = 1'b1;
                end
                if (!resp_valid[i] || resp_ready[i]) seen[i] = 1'b0;
            end
        end
    end

    task automatic set_req(input int i, input bit mul, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c, input logic [31:0] d, input logic [31:0] e);
        op_mul[i] = mul; op_a[i] = a; op_b[i] = b; op_c[i] = c; op_d[i] = d;
        op_rnd[i] = 3'(i + 1);
        exp_res[i] = e;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        @(negedge clk);
        while (busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (busy) check({name, "_idle_timeout"}, 64'(busy), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic wait_accepts(input int n, input string name);
        int got;
        got = 0;
        for (int k = 0; k < 100 && got < n; k++) begin
            @(negedge clk);
            got += $countones(req_valid & req_ready);
        end
        if (got < n) check({name, "_accept_timeout"}, 64'(got), 64'(n));
    endtask

    int t0;

    initial begin
        req_valid  = '0;
        resp_ready = '1;
        for (int i = 0; i < NR; i++) begin
            set_req(i, 1'b0, '0, '0, '0, '0, '0);
            drop_pend[i] = 1'b0;
            seen[i] = 1'b0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_data", 64'(resp_data[63:0] | resp_data[127:64]), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Saturation: pointer starts at NUM_REQ-1 so r0 wins first; slots
        // free up just in time for an unbroken r0..r3 rotation.
        auto_drop = 1'b0;
        set_req(0, 1'b1, 32'h0001_0001, 32'h0002_0002, '0, '0, 32'h0003_0003);
        set_req(1, 1'b0, '0, '0, 32'h00F0_0F00, 32'h0F00_00F0, 32'h0FF0_0FF0);
        set_req(2, 1'b1, 32'h1000_0000, 32'h0000_0001, '0, '0, 32'h1000_0001);
        set_req(3, 1'b0, '0, '0, 32'hAAAA_0000, 32'h5555_FFFF, 32'hFFFF_FFFF);
        acc_idx.delete(); acc_cyc.delete();
        t0 = cyc;
        req_valid = '1;
        wait_accepts(8, "sat");
        @(posedge clk); #1;
        req_valid = '0;
        auto_drop = 1'b1;
        if (acc_idx.size() >= 8) begin
            for (int k = 0; k < 8; k++) begin
                check($sformatf("sat_grant_idx%0d", k), 64'(acc_idx[k]), 64'(k % 4));
                check($sformatf("sat_grant_cyc%0d", k), 64'(acc_cyc[k]), 64'(t0 + k));
            end
        end else begin
            check("sat_accept_count", 64'(acc_idx.size()), 64'd8);
        end
        wait_idle("sat");

        // Single FP MUL on r0: result three cycles after issue
        set_req(0, 1'b1, 32'h3C00_4000, 32'h4200_3C00, '0, '0, 32'h3C00_4700);
        req_valid[0] = 1'b1;
        @(negedge clk);
        check("mul_grant_same_cycle", 64'(req_ready), 64'b0001);
        @(negedge clk);
        check("mul_busy", 64'(busy), 64'd1);
        wait_idle("mul");

        // Single FP ADD on r1: result two cycles after issue
        set_req(1, 1'b0, '0, '0, 32'h3C00_3C00, 32'h4000_4000, 32'h4200_4200);
        req_valid[1] = 1'b1;
        @(negedge clk);
        check("add_grant_same_cycle", 64'(req_ready), 64'b0010);
        wait_idle("add");

        // MUL r0 at T, ADD r1 at T+1: both results arrive together at T+3
        set_req(0, 1'b1, 32'h3C00_4000, 32'h4200_3C00, '0, '0, 32'h3C00_4700);
        set_req(1, 1'b0, '0, '0, 32'h3C00_3C00, 32'h4000_4000, 32'h4200_4200);
        acc_idx.delete(); acc_cyc.delete();
        req_valid[1:0] = 2'b11;
        wait_accepts(2, "dual");
        if (acc_idx.size() >= 2) begin
            check("dual_first_r0", 64'(acc_idx[0]), 64'd0);
            check("dual_second_r1", 64'(acc_idx[1]), 64'd1);
            check("dual_back_to_back", 64'(acc_cyc[1] - acc_cyc[0]), 64'd1);
        end
        wait_idle("dual");

        // Outstanding block: r2 keeps req_valid high with its response unread
        auto_drop = 1'b0;
        resp_ready[2] = 1'b0;
        set_req(2, 1'b0, '0, '0, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678);
        req_valid[2] = 1'b1;
        @(negedge clk);
        check("blk_first_grant", 64'(req_ready), 64'b0100);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("blk_ready_held_low", 64'(req_ready[2]), 64'd0);
        end
        check("blk_resp_held", 64'(resp_valid[2]), 64'd1);
        @(posedge clk); #1;
        resp_ready[2] = 1'b1;
        auto_drop = 1'b1;
        @(negedge clk);
        check("blk_ready_hs_cycle", 64'(req_ready[2]), 64'd0);
        @(negedge clk);
        check("blk_ready_after_hs", 64'(req_ready[2]), 64'd1);
        wait_idle("blk");

        // Reset with ops in flight: nothing may surface afterwards
        set_req(3, 1'b1, 32'h0000_0001, 32'h0000_0002, '0, '0, 32'h0000_0003);
        set_req(0, 1'b1, 32'h0000_0010, 32'h0000_0020, '0, '0, 32'h0000_0030);
        set_req(1, 1'b1, 32'h0000_0100, 32'h0000_0200, '0, '0, 32'h0000_0300);
        req_valid = 4'b1011;
        wait_accepts(3, "rst");
        @(posedge clk); #1;
        rst = 1'b1;
        req_valid = '0;
        sb_q.delete();
        for (int i = 0; i < NR; i++) seen[i] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_resp_valid", 64'(resp_valid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_req_ready", 64'(req_ready), 64'd0);
        repeat (8) @(negedge clk);
        check("midrst_no_late_resp", 64'(resp_valid), 64'd0);

        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
